// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter
//
// Two-requester burst-write arbiter in front of a single write port of a RAM.
// A requester raises i_reqN with a base address and a burst length. The
// arbiter grants one requester at a time (round-robin when both ask), pops
// words from the winner with a one-cycle o_rdN strobe, and writes each word
// to consecutive RAM addresses. It finishes with a one-cycle o_doneN pulse.
//
// Every burst runs IDLE -> GRANT -> (LOAD -> WRITE) x len -> DONE -> IDLE.
// A zero-length burst goes GRANT -> DONE with no pop and no write.
//
// Ports
//   i_clk            single clock, all state on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_reqN           level burst request from requester N
//   i_addrN          burst base address from requester N
//   i_lenN           burst length (words) from requester N
//   i_dataN          word currently presented by requester N
//   o_gntN           grant, high from GRANT through DONE of N's burst
//   o_rdN            one-cycle pop strobe to requester N
//   o_doneN          one-cycle burst-complete pulse to requester N
//   o_ram_address    RAM write address (held outside WRITE)
//   o_ram_data       RAM write data (held outside WRITE)
//   o_ram_wren       RAM write enable, high only in WRITE
module ram_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [LEN_W-1:0]  i_len0,
  input  logic [LEN_W-1:0]  i_len1,
  input  logic [DATA_W-1:0] i_data0,
  input  logic [DATA_W-1:0] i_data1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rd0,
  output logic              o_rd1,
  output logic              o_done0,
  output logic              o_done1,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_wren
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_r;
  logic                winner_r;     // owner of the current burst (0 or 1)
  logic                last_r;       // last requester served; 1 after reset so 0 wins first
  logic [ADDR_W-1:0]   addr_cnt_r;   // next RAM address of the burst
  logic [LEN_W-1:0]    len_r;        // latched burst length
  logic [LEN_W-1:0]    cnt_r;        // words written so far

  logic                gnt0_r;
  logic                gnt1_r;
  logic                rd0_r;
  logic                rd1_r;
  logic                done0_r;
  logic                done1_r;
  logic [ADDR_W-1:0]   ram_address_r;
  logic [DATA_W-1:0]   ram_data_r;
  logic                ram_wren_r;

  logic                any_req_s;
  logic                pick_s;       // requester that wins if sampled now
  logic [ADDR_W-1:0]   pick_addr_s;
  logic [LEN_W-1:0]    pick_len_s;
  logic [DATA_W-1:0]   win_data_s;   // word presented by the current owner
  logic [LEN_W:0]      cnt_next_s;   // one bit wider so a 15-word burst cannot overflow

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    any_req_s = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      pick_s = ~last_r;
    end else if (i_req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Burst parameters of the requester picked in IDLE.
  always_comb begin
    if (pick_s) begin
      pick_addr_s = i_addr1;
      pick_len_s  = i_len1;
    end else begin
      pick_addr_s = i_addr0;
      pick_len_s  = i_len0;
    end
  end

  // Data mux from the current burst owner.
  always_comb begin
    if (winner_r) begin
      win_data_s = i_data1;
    end else begin
      win_data_s = i_data0;
    end
  end

  // Word count after the write in progress completes.
  always_comb begin
    cnt_next_s = {1'b0, cnt_r} + (LEN_W+1)'(1);
  end

  // Arbiter FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= ST_IDLE;
      winner_r      <= 1'b0;
      last_r        <= 1'b1;
      addr_cnt_r    <= '0;
      len_r         <= '0;
      cnt_r         <= '0;
      gnt0_r        <= 1'b0;
      gnt1_r        <= 1'b0;
      rd0_r         <= 1'b0;
      rd1_r         <= 1'b0;
      done0_r       <= 1'b0;
      done1_r       <= 1'b0;
      ram_address_r <= '0;
      ram_data_r    <= '0;
      ram_wren_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rd0_r      <= 1'b0;
          rd1_r      <= 1'b0;
          done0_r    <= 1'b0;
          done1_r    <= 1'b0;
          ram_wren_r <= 1'b0;
          if (any_req_s) begin
            winner_r   <= pick_s;
            addr_cnt_r <= pick_addr_s;
            len_r      <= pick_len_s;
            cnt_r      <= '0;
            gnt0_r     <= ~pick_s;
            gnt1_r     <= pick_s;
            state_r    <= ST_GRANT;
          end else begin
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        ST_GRANT: begin
          if (len_r != '0) begin
            // Pop the first word during LOAD.
            rd0_r   <= ~winner_r;
            rd1_r   <= winner_r;
            state_r <= ST_LOAD;
          end else begin
            // Zero-length burst: straight to completion, nothing popped.
            done0_r <= ~winner_r;
            done1_r <= winner_r;
            last_r  <= winner_r;
            state_r <= ST_DONE;
          end
        end

        ST_LOAD: begin
          // Capture the owner's word and the current address for WRITE.
          rd0_r         <= 1'b0;
          rd1_r         <= 1'b0;
          ram_data_r    <= win_data_s;
          ram_address_r <= addr_cnt_r;
          ram_wren_r    <= 1'b1;
          state_r       <= ST_WRITE;
        end

        ST_WRITE: begin
          ram_wren_r <= 1'b0;
          // Address wraps naturally modulo 2^ADDR_W.
          addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
          cnt_r      <= cnt_next_s[LEN_W-1:0];
          if (cnt_next_s < {1'b0, len_r}) begin
            rd0_r   <= ~winner_r;
            rd1_r   <= winner_r;
            state_r <= ST_LOAD;
          end else begin
            done0_r <= ~winner_r;
            done1_r <= winner_r;
            last_r  <= winner_r;
            state_r <= ST_DONE;
          end
        end

        ST_DONE: begin
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          // Illegal encoding: drop every strobe and grant and restart.
          gnt0_r     <= 1'b0;
          gnt1_r     <= 1'b0;
          rd0_r      <= 1'b0;
          rd1_r      <= 1'b0;
          done0_r    <= 1'b0;
          done1_r    <= 1'b0;
          ram_wren_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_gnt0        = gnt0_r;
  assign o_gnt1        = gnt1_r;
  assign o_rd0         = rd0_r;
  assign o_rd1         = rd1_r;
  assign o_done0       = done0_r;
  assign o_done1       = done1_r;
  assign o_ram_address = ram_address_r;
  assign o_ram_data    = ram_data_r;
  assign o_ram_wren    = ram_wren_r;

endmodule

// File: tb/tb_ram_write_arbiter.sv
`timescale 1ns/1ps
module tb_ram_write_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int ASPAN  = 1 << ADDR_W;
  localparam int DEPTH  = 1024;

  logic              i_clk   = 1'b0;
  logic              i_rst_n = 1'b1;
  logic              i_req0  = 1'b0;
  logic              i_req1  = 1'b0;
  logic [ADDR_W-1:0] i_addr0 = '0;
  logic [ADDR_W-1:0] i_addr1 = '0;
  logic [LEN_W-1:0]  i_len0  = '0;
  logic [LEN_W-1:0]  i_len1  = '0;
  logic [DATA_W-1:0] i_data0 = '0;
  logic [DATA_W-1:0] i_data1 = '0;
  logic              o_gnt0, o_gnt1, o_rd0, o_rd1, o_done0, o_done1;
  logic [ADDR_W-1:0] o_ram_address;
  logic [DATA_W-1:0] o_ram_data;
  logic              o_ram_wren;

  always #5 i_clk = ~i_clk;

  ram_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0(i_req0), .i_req1(i_req1),
    .i_addr0(i_addr0), .i_addr1(i_addr1),
    .i_len0(i_len0), .i_len1(i_len1),
    .i_data0(i_data0), .i_data1(i_data1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
    .o_rd0(o_rd0), .o_rd1(o_rd1),
    .o_done0(o_done0), .o_done1(o_done1),
    .o_ram_address(o_ram_address), .o_ram_data(o_ram_data), .o_ram_wren(o_ram_wren)
  );

  int errors = 0;
  int checks = 0;

  // Requester-side word streams: each requester presents words[ptr], ptr advances on a pop.
  logic [DATA_W-1:0] words0 [DEPTH];
  logic [DATA_W-1:0] words1 [DEPTH];
  int ptr0 = 0;
  int ptr1 = 0;

  // Reference model: a burst is described by owner, base, length, first word index and
  // the cycle offset j since the grant; every output follows from j by arithmetic.
  bit m_busy  = 1'b0;
  bit m_owner = 1'b0;
  bit m_last  = 1'b1;
  int m_j = 0, m_base = 0, m_len = 0, m_w0 = 0;
  int m_addr = 0, m_data = 0;

  typedef struct {
    bit req0; bit req1; int a0; int l0; int a1; int l1; bit hold;
    int exp_win; int exp_writes; int exp_first; int exp_last; int exp_cycles;
  } row_t;
  row_t rows [7];

  int win, nw, nr, nd, ng, first_a, last_a, overlap, gap;
  bit prev_g, g;
  int owners[$];
  int gaps[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_data();
    i_data0 = words0[ptr0 % DEPTH];
    i_data1 = words1[ptr1 % DEPTH];
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_last = 1'b1; m_j = 0; m_addr = 0; m_data = 0;
  endtask

  // Effect of one rising edge given the inputs currently driven.
  task automatic model_edge();
    if (m_busy) begin
      m_j++;
      if (m_j == 2*m_len + 1) m_last = m_owner;
      if (m_j == 2*m_len + 2) m_busy = 1'b0;
    end else if (i_req0 || i_req1) begin
      if (i_req0 && i_req1) m_owner = !m_last;
      else m_owner = i_req1;
      m_busy = 1'b1;
      m_j    = 0;
      m_base = m_owner ? int'(i_addr1) : int'(i_addr0);
      m_len  = m_owner ? int'(i_len1) : int'(i_len0);
      m_w0   = m_owner ? ptr1 : ptr0;
    end
  endtask

  // Compare every output against what the model says for this cycle.
  task automatic model_check();
    bit g0, g1, r0, r1, d0, d1, w;
    int i;
    g0 = 0; g1 = 0; r0 = 0; r1 = 0; d0 = 0; d1 = 0; w = 0;
    if (m_busy) begin
      g0 = !m_owner; g1 = m_owner;
      if (m_j % 2 == 1 && m_j < 2*m_len + 1) begin r0 = !m_owner; r1 = m_owner; end
      if (m_j % 2 == 0 && m_j >= 2 && m_j <= 2*m_len) begin
        w = 1;
        i = (m_j - 2) / 2;
        m_addr = (m_base + i) % ASPAN;
        m_data = m_owner ? int'(words1[(m_w0 + i) % DEPTH]) : int'(words0[(m_w0 + i) % DEPTH]);
      end
      if (m_j == 2*m_len + 1) begin d0 = !m_owner; d1 = m_owner; end
    end
    check("ctrl{gnt0,gnt1,rd0,rd1,done0,done1,wren}",
          int'({o_gnt0, o_gnt1, o_rd0, o_rd1, o_done0, o_done1, o_ram_wren}),
          int'({g0, g1, r0, r1, d0, d1, w}));
    check("ram_address", int'(o_ram_address), m_addr);
    check("ram_data", int'(o_ram_data), m_data);
  endtask

  // One clock: called at the falling edge with the next inputs already driven.
  task automatic cycle();
    bit pop0, pop1;
    pop0 = o_rd0;
    pop1 = o_rd1;
    model_edge();
    @(posedge i_clk);
    @(negedge i_clk);
    if (pop0) ptr0++;
    if (pop1) ptr1++;
    drive_data();
    model_check();
  endtask

  // Assert reset between edges, check outputs clear at once, release on a falling edge.
  task automatic apply_reset();
    i_rst_n = 1'b0;
    #1;
    check("reset_ctrl", int'({o_gnt0, o_gnt1, o_rd0, o_rd1, o_done0, o_done1, o_ram_wren}), 0);
    check("reset_address", int'(o_ram_address), 0);
    check("reset_data", int'(o_ram_data), 0);
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] spec_words [8];
    spec_words = '{8'd1, 8'd10, 8'd20, 8'd117, 8'd15, 8'd25, 8'd50, 8'd30};
    for (int i = 0; i < DEPTH; i++) begin
      words0[i] = DATA_W'($urandom);
      words1[i] = DATA_W'($urandom);
    end
    for (int i = 0; i < 8; i++) words0[i] = spec_words[i];

    //          req0 req1 a0  l0  a1  l1 hold | win writes first last cycles
    rows[0] = '{1'b1, 1'b0,  0,  8,  0,  0, 1'b0, 0,  8,  0,  7, 18};  // single 8-word burst
    rows[1] = '{1'b0, 1'b1,  0,  0, 30,  4, 1'b0, 1,  4, 30,  1, 10};  // address wrap
    rows[2] = '{1'b1, 1'b0,  9,  0,  0,  0, 1'b0, 0,  0,  0,  0,  2};  // zero length
    rows[3] = '{1'b1, 1'b1, 10,  2,  3,  3, 1'b0, 0,  2, 10, 11,  6};  // contention after reset
    rows[4] = '{1'b0, 1'b1,  0,  0,  5,  5, 1'b0, 1,  5,  5,  9, 12};  // request dropped after grant
    rows[5] = '{1'b1, 1'b0, 20, 15,  0,  0, 1'b1, 0, 15, 20,  2, 32};  // max length, inputs scrambled
    rows[6] = '{1'b0, 1'b1,  0,  0, 31,  1, 1'b1, 1,  1, 31, 31,  4};  // one word at top address

    #2;
    apply_reset();

    // Table-driven single bursts.
    for (int r = 0; r < 7; r++) begin
      apply_reset();
      ptr0 = 0; ptr1 = 0; drive_data();
      i_req0 = rows[r].req0; i_req1 = rows[r].req1;
      i_addr0 = ADDR_W'(rows[r].a0); i_len0 = LEN_W'(rows[r].l0);
      i_addr1 = ADDR_W'(rows[r].a1); i_len1 = LEN_W'(rows[r].l1);
      win = -1; nw = 0; nr = 0; nd = 0; ng = 0; first_a = -1; last_a = -1;
      for (int c = 0; c < 60; c++) begin
        cycle();
        if (o_gnt0 || o_gnt1) begin
          ng++;
          if (win < 0) win = o_gnt1 ? 1 : 0;
        end
        if (o_ram_wren) begin
          if (nw == 0) first_a = int'(o_ram_address);
          last_a = int'(o_ram_address);
          nw++;
        end
        if (o_rd0 || o_rd1) nr++;
        if (o_done0 || o_done1) begin
          nd++;
          i_req0 = 1'b0; i_req1 = 1'b0;
        end else if (ng == 1 && !rows[r].hold) begin
          i_req0 = 1'b0; i_req1 = 1'b0;
        end else if (ng > 0 && rows[r].hold) begin
          i_addr0 = ADDR_W'($urandom); i_len0 = LEN_W'($urandom);
          i_addr1 = ADDR_W'($urandom); i_len1 = LEN_W'($urandom);
        end
        if (ng > 0 && !o_gnt0 && !o_gnt1) break;
      end
      check($sformatf("row%0d_winner", r), win, rows[r].exp_win);
      check($sformatf("row%0d_writes", r), nw, rows[r].exp_writes);
      check($sformatf("row%0d_pops", r), nr, rows[r].exp_writes);
      check($sformatf("row%0d_done_pulses", r), nd, 1);
      check($sformatf("row%0d_grant_cycles", r), ng, rows[r].exp_cycles);
      if (rows[r].exp_writes > 0) begin
        check($sformatf("row%0d_first_addr", r), first_a, rows[r].exp_first);
        check($sformatf("row%0d_last_addr", r), last_a, rows[r].exp_last);
      end
    end

    // Contention held from reset: grants alternate with one idle cycle between bursts.
    apply_reset();
    i_req0 = 1'b1; i_req1 = 1'b1;
    i_addr0 = 5'd0; i_len0 = 4'd2; i_addr1 = 5'd16; i_len1 = 4'd1;
    owners.delete(); gaps.delete();
    overlap = 0; gap = 0; prev_g = 1'b0;
    for (int c = 0; c < 100 && owners.size() < 4; c++) begin
      cycle();
      if (o_gnt0 && o_gnt1) overlap++;
      g = o_gnt0 || o_gnt1;
      if (g && !prev_g) begin
        owners.push_back(o_gnt1 ? 1 : 0);
        if (owners.size() > 1) gaps.push_back(gap);
      end
      if (!g) gap++;
      else gap = 0;
      prev_g = g;
    end
    check("contention_grant_count", owners.size(), 4);
    for (int i = 0; i < owners.size(); i++) check($sformatf("contention_owner%0d", i), owners[i], i % 2);
    for (int i = 0; i < gaps.size(); i++) check($sformatf("contention_gap%0d", i), gaps[i], 1);
    check("contention_overlap", overlap, 0);

    // Reset after the 3rd write of an 8-word burst, then a fresh burst from its own base.
    apply_reset();
    ptr0 = 0; drive_data();
    i_req0 = 1'b1; i_req1 = 1'b0; i_addr0 = 5'd4; i_len0 = 4'd8;
    nw = 0;
    for (int c = 0; c < 40 && nw < 3; c++) begin
      cycle();
      if (o_ram_wren) nw++;
      if (o_gnt0) i_req0 = 1'b0;
    end
    check("abort_third_write_seen", nw, 3);
    cycle();
    apply_reset();
    repeat (4) cycle();
    i_req0 = 1'b1; i_addr0 = 5'd12; i_len0 = 4'd2;
    nw = 0; nd = 0; first_a = -1;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (o_gnt0) i_req0 = 1'b0;
      if (o_ram_wren) begin
        if (nw == 0) first_a = int'(o_ram_address);
        nw++;
      end
      if (o_done0 || o_done1) nd++;
    end
    check("after_abort_first_addr", first_a, 12);
    check("after_abort_writes", nw, 2);
    check("after_abort_done_pulses", nd, 1);

    // Random traffic checked cycle by cycle against the model.
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) i_req0 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) i_req1 = 1'($urandom_range(0, 1));
      i_addr0 = ADDR_W'($urandom);
      i_addr1 = ADDR_W'($urandom);
      i_len0 = ($urandom_range(0, 4) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 3));
      i_len1 = ($urandom_range(0, 4) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) apply_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_write_arbiter.md
RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter LEN_W, default 4, burst length field width (max burst 15 words).
REQ-004 i_clk  input  1  single clock; all state on rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_req0 / i_req1  input  1 each  burst-write request from requester 0 / 1 (level).
REQ-007 i_addr0 / i_addr1  input  ADDR_W each  burst base RAM address.
REQ-008 i_len0 / i_len1  input  LEN_W each  burst length in words.
REQ-009 i_data0 / i_data1  input  DATA_W each  current word from requester.
REQ-010 o_gnt0 / o_gnt1  output  1 each  grant; high for the whole owned burst.
REQ-011 o_rd0 / o_rd1  output  1 each  one-cycle pop strobe; requester presents the next word on the following cycle.
REQ-012 o_done0 / o_done1  output  1 each  one-cycle burst-complete pulse.
REQ-013 o_ram_address  output  ADDR_W  RAM write address.
REQ-014 o_ram_data  output  DATA_W  RAM write data.
REQ-015 o_ram_wren  output  1  RAM write enable, one cycle per word.

Function
REQ-016 FSM states: IDLE, GRANT, LOAD, WRITE, DONE. Any other encoding returns to IDLE.
REQ-017 IDLE behaviour.
- Requests are sampled only in IDLE.
- If any i_reqN is high, the arbiter picks a winner, latches its i_addrN into the address counter and its i_lenN into the length register, and moves to GRANT.
- Otherwise it stays in IDLE.
REQ-018 Arbitration is round-robin. If both requests are high, the requester not served last wins. After reset, requester 0 has priority.
REQ-019 The last-served pointer updates on entry to DONE.
REQ-020 o_gntN for the winner is high from GRANT through DONE inclusive. Both grants are never high together.
REQ-021 GRANT lasts one cycle. It then goes to LOAD if the latched length is nonzero, else to DONE (zero-length burst: no write, no pop).
REQ-022 LOAD lasts one cycle.
- Winner's o_rdN is high.
- The winner's i_dataN is registered into o_ram_data at the end of the cycle.
REQ-023 WRITE lasts one cycle.
- o_ram_wren is high; o_ram_address is the counter value.
- At the end of the cycle the counter increments and the words-written count increments.
- Next state is LOAD if words written < length, else DONE.
REQ-024 The address counter wraps modulo 2^ADDR_W (31 + 1 = 0). Burst length is not clipped at the wrap.
REQ-025 DONE lasts one cycle. The winner's o_doneN is high; the next state is IDLE.
REQ-026 Burst latency for length L ≥ 1 is 2 + 2L cycles from leaving IDLE to returning to IDLE. The first o_ram_wren occurs 3 cycles after the IDLE sampling edge.
REQ-027 Requester side during a burst.
- Deasserting i_reqN mid-burst does not abort it; the burst completes.
- Changing i_addrN or i_lenN mid-burst has no effect.
REQ-028 A request held high through DONE is re-arbitrated in the next IDLE cycle, so back-to-back bursts are separated by exactly one IDLE cycle.
REQ-029 o_ram_wren is low in every state except WRITE. o_ram_data and o_ram_address hold their values outside WRITE.

Reset
REQ-030 While i_rst_n is low, outputs are forced immediately (asynchronously):
- FSM = IDLE.
- o_gnt*, o_rd*, o_done*, o_ram_wren = 0.
- o_ram_address = 0, o_ram_data = 0.
- Priority pointer selects requester 0.
REQ-031 Reset asserted mid-burst aborts the burst with no further writes. After release, the FSM restarts from IDLE and no o_done is issued for the aborted burst.

Verification
REQ-032 Single burst: i_req0 = 1, addr = 0, len = 8, data 1, 10, 20, 117, 15, 25, 50, 30 -> 8 wren pulses at addresses 0..7 with those data, o_done0 one cycle, 18 cycles total.
REQ-033 Contention: i_req0 and i_req1 both held from reset -> grants alternate 0, 1, 0, 1, never overlapping, with one IDLE cycle between bursts.
REQ-034 Wrap: i_req1 = 1, addr = 30, len = 4 -> writes at addresses 30, 31, 0, 1.
REQ-035 Zero length: i_req0 = 1, len = 0 -> GRANT then DONE, o_done0 pulse, no o_rd0 pulse, no o_ram_wren.
REQ-036 Reset mid-burst: i_rst_n low after the 3rd write of an 8-word burst -> all outputs 0 immediately, no more writes, and the next request after release is served from its own base address.
REQ-037 Request drop: i_req1 deasserted after GRANT with len = 5 -> all 5 writes still occur, followed by o_done1.
